// File: rtl/cross_bar_pkg.sv
// ----------------------------------------------------------------------------
// Module  : cross_bar_pkg
// Brief   : Shared types and constants for the crossbar and its slave endpoints.
// Revision: 1.1 - slave command encoding and slave FSM state type
// ----------------------------------------------------------------------------
`default_nettype none

package cross_bar_pkg;

    localparam int MASTER_N = 4;
    localparam int SLAVE_N  = 4;
    localparam int MASTER_W = $clog2(MASTER_N);
    localparam int SLAVE_W  = $clog2(SLAVE_N);

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } slave_state_t;

endpackage

`default_nettype wire

// File: rtl/cross_bar_slave_mem_if.sv
// ----------------------------------------------------------------------------
// Module  : cross_bar_slave_mem_if
// Brief   : Request/ack bus between a crossbar slave port and its responder.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface cross_bar_slave_mem_if;
    import cross_bar_pkg::*;

    logic  slave_req;
    addr_t slave_addr;
    logic  slave_cmd;
    data_t slave_wdata;
    logic  slave_ack;
    data_t slave_rdata;

    modport master (
        output slave_req, slave_addr, slave_cmd, slave_wdata,
        input  slave_ack, slave_rdata
    );

    modport slave (
        input  slave_req, slave_addr, slave_cmd, slave_wdata,
        output slave_ack, slave_rdata
    );

endinterface

`default_nettype wire

// File: rtl/cross_bar_slave_lfsr.sv
// ----------------------------------------------------------------------------
// Module  : cross_bar_slave_lfsr
// Brief   : 8-bit Fibonacci LFSR (taps 8,6,5,4) advancing once per step pulse.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cross_bar_slave_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  wire logic       clk,
    input  wire logic       areset,
    input  wire logic       step,
    output logic [7:0]      state
);

    logic w_feedback;

    assign w_feedback = state[7] ^ state[5] ^ state[4] ^ state[3];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= SEED;
        end else if (step) begin
            state <= {state[6:0], w_feedback};
        end
    end

endmodule

`default_nettype wire

// File: rtl/cross_bar_slave_mem.sv
// ----------------------------------------------------------------------------
// Module  : cross_bar_slave_mem
// Brief   : Word-addressed memory slave with programmable wait states and a
//           one-cycle ack. CROSS_BAR_SLAVE_LFSR_WAIT_EN adds 0..3 random stalls.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cross_bar_slave_mem
    import cross_bar_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         WAIT_CYCLES = 0,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  wire logic              clk,
    input  wire logic              areset,
    cross_bar_slave_mem_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 5;

    slave_state_t     r_state;
    slave_state_t     w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load;
    logic [IDX_W-1:0] r_idx;
    logic             r_cmd;
    data_t            r_wdata;
    data_t            r_mem [DEPTH];
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && bus.slave_req;

`ifdef CROSS_BAR_SLAVE_LFSR_WAIT_EN
    logic [7:0] w_lfsr;

    cross_bar_slave_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .areset (areset),
        .step   (w_accept),
        .state  (w_lfsr)
    );

    // Stall for this transaction comes from the state before the step
    assign w_load = CNT_W'(WAIT_CYCLES) + {3'b000, w_lfsr[1:0]};
`else
    // Seed is only consumed when the stall LFSR is built in
    if (LFSR_SEED == 8'h00) begin : g_seed_unused
    end

    assign w_load = CNT_W'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.slave_req) begin
                    w_next = (w_load == '0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_next = ACK;
                end
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_cmd   <= CMD_READ;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= w_load;
            r_idx   <= bus.slave_addr[IDX_W+1:2];
            r_cmd   <= bus.slave_cmd;
            r_wdata <= bus.slave_wdata;
        end else if (r_state == WAIT) begin
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    // Write commits on the edge leaving ACK; a reset before then discards it
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == ACK) && (r_cmd == CMD_WRITE)) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_comb begin
        bus.slave_ack   = 1'b0;
        bus.slave_rdata = '0;
        if (r_state == ACK) begin
            bus.slave_ack = 1'b1;
            if (r_cmd == CMD_READ) begin
                bus.slave_rdata = r_mem[r_idx];
            end
        end
    end

endmodule

`default_nettype wire
